bcd_conv_seq: RTL



---
 rtl/bcd_conv_seq.sv | 123 ++++++++++++
 1 files changed

// File: rtl/bcd_conv_seq.sv
// rtl/bcd_conv_seq.sv - sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
//
// Ports:
//   clk    system clock, rising-edge active
//   res    asynchronous active-high reset
//   start  conversion request; accepted only while idle
//   bin    binary value, sampled on an accepted start
//   bcd    registered result, digit i at [4i+3:4i], digit 0 = ones
//   busy   high while a conversion is in progress
//   done   one-cycle pulse when bcd is updated
//   blank  (only with BCD_BLANK_EN) leading-zero blanking per digit, blank[0] always 0
//
// Optional feature macro: BCD_BLANK_EN

module bcd_conv_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done
`ifdef BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]          state;
    logic [WIDTH-1:0]    sreg;
    logic [4*DIGITS-1:0] scratch;
    logic [4*DIGITS-1:0] adj;
    logic [4*DIGITS-1:0] scratch_nx;
    logic [CW-1:0]       cnt;

    // Add 3 to each digit >= 5 independently (no inter-digit carry), then
    // shift the next binary bit in. The top digit's shifted-out MSB is
    // dropped; it is always zero when DIGITS is sized correctly.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        scratch_nx = (adj << 1) | {{(4*DIGITS-1){1'b0}}, sreg[WIDTH-1]};
    end

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0] blank_nx;
    logic              zero_above;

    // A digit is blanked when it and every more significant digit are zero;
    // the ones digit is never blanked so a zero result still shows "0".
    always_comb begin
        blank_nx   = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above  = zero_above & (scratch[4*i +: 4] == 4'd0);
            blank_nx[i] = zero_above;
        end
    end
`endif

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state   <= S_IDLE;
            sreg    <= '0;
            scratch <= '0;
            cnt     <= '0;
            bcd     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef BCD_BLANK_EN
            blank   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sreg    <= bin;
                        scratch <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    scratch <= scratch_nx;
                    sreg    <= sreg << 1;
                    cnt     <= cnt + 1'b1;
                    // cnt holds the index of the bit being shifted this edge.
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    bcd   <= scratch;
                    done  <= 1'b1;
                    busy  <= 1'b0;
`ifdef BCD_BLANK_EN
                    blank <= blank_nx;
`endif
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
